// File: rtl/svga_scan_ctrl_pkg.sv
// Shared timing defaults, scan FSM states and the sync bundle type for the
// SVGA scan controller.
package svga_scan_ctrl_pkg;

    localparam int unsigned H_CNT_W = 11;
    localparam int unsigned V_CNT_W = 10;

    localparam int unsigned DEF_H_ACTIVE = 800;
    localparam int unsigned DEF_H_FP     = 56;
    localparam int unsigned DEF_H_SYNC   = 120;
    localparam int unsigned DEF_H_BP     = 64;
    localparam int unsigned DEF_V_ACTIVE = 600;
    localparam int unsigned DEF_V_FP     = 37;
    localparam int unsigned DEF_V_SYNC   = 6;
    localparam int unsigned DEF_V_BP     = 23;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } scan_state_t;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic de;
    } sync_bus_t;

    function automatic logic in_window(input int unsigned val,
                                       input int unsigned lo,
                                       input int unsigned len);
        return (val >= lo) && (val < lo + len);
    endfunction

endpackage

// File: rtl/svga_scan_ctrl_if.sv
// Scan-controller bundle: scan request in, counters, frame-store read strobe
// and delayed sync/DE out.
interface svga_scan_ctrl_if
    import svga_scan_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 19
);
    logic               enable;
    logic [H_CNT_W-1:0] h_count;
    logic [V_CNT_W-1:0] v_count;
    logic               pix_rd_en;
    logic [ADDR_W-1:0]  pix_addr;
    logic               hsync;
    logic               vsync;
    logic               de;
    logic               frame_start;
    logic               running;

    modport master (
        input  enable,
        output h_count, v_count, pix_rd_en, pix_addr,
        output hsync, vsync, de, frame_start, running
    );

    modport slave (
        output enable,
        input  h_count, v_count, pix_rd_en, pix_addr,
        input  hsync, vsync, de, frame_start, running
    );
endinterface

// File: rtl/svga_scan_ctrl_sync_delay_line.sv
// Fixed-depth shift register that aligns hsync/vsync/de with the frame-store
// read latency; async reset loads a caller-supplied idle pattern.
module sync_delay_line #(
    parameter int unsigned W     = 3,
    parameter int unsigned DEPTH = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] i_rst_val,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_pipe [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) r_pipe[i] <= i_rst_val;
        end else begin
            r_pipe[0] <= i_d;
            for (int unsigned i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign o_q = r_pipe[DEPTH-1];
endmodule

// File: rtl/svga_scan_ctrl.sv
// 800x600@72Hz scan controller: run/stop FSM, raster counters, linear read
// address generation and latency-matched sync/DE.
module svga_scan_ctrl
    import svga_scan_ctrl_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
    parameter int unsigned H_FP       = DEF_H_FP,
    parameter int unsigned H_SYNC     = DEF_H_SYNC,
    parameter int unsigned H_BP       = DEF_H_BP,
    parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
    parameter int unsigned V_FP       = DEF_V_FP,
    parameter int unsigned V_SYNC     = DEF_V_SYNC,
    parameter int unsigned V_BP       = DEF_V_BP,
    parameter logic        SYNC_POL   = 1'b1,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned ADDR_W     = 19
) (
    input  logic clk,
    input  logic reset_n,
    svga_scan_ctrl_if.master bus
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [H_CNT_W-1:0] H_LAST  = H_CNT_W'(H_TOTAL - 1);
    localparam logic [V_CNT_W-1:0] V_LAST  = V_CNT_W'(V_TOTAL - 1);
    localparam logic [H_CNT_W-1:0] H_ACT_C = H_CNT_W'(H_ACTIVE);
    localparam logic [V_CNT_W-1:0] V_ACT_C = V_CNT_W'(V_ACTIVE);
    localparam logic               INACT   = ~SYNC_POL;
    localparam sync_bus_t          IDLE_SYNC = '{hsync: INACT, vsync: INACT, de: 1'b0};

    scan_state_t        r_state, w_state_nxt;
    logic [H_CNT_W-1:0] r_h, w_h_nxt;
    logic [V_CNT_W-1:0] r_v, w_v_nxt;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_frame_start;
    sync_bus_t          r_stage0, w_stage0_nxt, w_delayed;
    logic               w_run, w_run_nxt, w_frame_end, w_origin_nxt;

    assign w_run       = (r_state != IDLE);
    assign w_run_nxt   = (w_state_nxt != IDLE);
    assign w_frame_end = (r_h == H_LAST) && (r_v == V_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // Frame completion outranks a re-raised enable: the last clk of a
    // stopping frame always lands in IDLE, restarting one clk later.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:     if (bus.enable) w_state_nxt = RUN;
            RUN:      if (!bus.enable) w_state_nxt = STOPPING;
            STOPPING: begin
                if (w_frame_end)     w_state_nxt = IDLE;
                else if (bus.enable) w_state_nxt = RUN;
            end
            default:  w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_h_nxt = '0;
        w_v_nxt = '0;
        if (w_run) begin
            if (r_h == H_LAST) begin
                w_h_nxt = '0;
                w_v_nxt = (r_v == V_LAST) ? '0 : r_v + V_CNT_W'(1);
            end else begin
                w_h_nxt = r_h + H_CNT_W'(1);
                w_v_nxt = r_v;
            end
        end
        w_origin_nxt = (w_h_nxt == '0) && (w_v_nxt == '0);
        w_stage0_nxt.de    = w_run_nxt && (w_h_nxt < H_ACT_C) && (w_v_nxt < V_ACT_C);
        w_stage0_nxt.hsync = (w_run_nxt && in_window(32'(w_h_nxt), H_ACTIVE + H_FP, H_SYNC))
                             ? SYNC_POL : INACT;
        w_stage0_nxt.vsync = (w_run_nxt && in_window(32'(w_v_nxt), V_ACTIVE + V_FP, V_SYNC))
                             ? SYNC_POL : INACT;
    end

    // Address counts completed reads instead of computing v*H_ACTIVE+h.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_h           <= '0;
            r_v           <= '0;
            r_addr        <= '0;
            r_frame_start <= 1'b0;
            r_stage0      <= IDLE_SYNC;
        end else begin
            r_h           <= w_h_nxt;
            r_v           <= w_v_nxt;
            r_frame_start <= w_run_nxt && w_origin_nxt;
            r_stage0      <= w_stage0_nxt;
            if (w_origin_nxt)     r_addr <= '0;
            else if (r_stage0.de) r_addr <= r_addr + ADDR_W'(1);
        end
    end

    sync_delay_line #(
        .W     (3),
        .DEPTH (RD_LATENCY)
    ) u_sync_delay (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_rst_val (IDLE_SYNC),
        .i_d       (r_stage0),
        .o_q       (w_delayed)
    );

    assign bus.h_count     = r_h;
    assign bus.v_count     = r_v;
    assign bus.pix_rd_en   = r_stage0.de;
    assign bus.pix_addr    = r_addr;
    assign bus.hsync       = w_delayed.hsync;
    assign bus.vsync       = w_delayed.vsync;
    assign bus.de          = w_delayed.de;
    assign bus.frame_start = r_frame_start;
    assign bus.running     = w_run;
endmodule

// File: tb/tb_svga_scan_ctrl.sv
// Directed bench: full-size timing for line checks, and a miniature raster
// (15x8, latency 3, active-low syncs) for frame, stop/restart and reset checks.
module tb_svga_scan_ctrl;
    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    svga_scan_ctrl_if #(.ADDR_W(19)) bus_a ();
    svga_scan_ctrl_if #(.ADDR_W(5))  bus_b ();

    svga_scan_ctrl #(
        .RD_LATENCY (1),
        .ADDR_W     (19)
    ) dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_a)
    );

    svga_scan_ctrl #(
        .H_ACTIVE   (8),
        .H_FP       (2),
        .H_SYNC     (3),
        .H_BP       (2),
        .V_ACTIVE   (4),
        .V_FP       (1),
        .V_SYNC     (2),
        .V_BP       (1),
        .SYNC_POL   (1'b0),
        .RD_LATENCY (3),
        .ADDR_W     (5)
    ) dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int hs_cnt = 0;
        int rd1 = 0;
        int rd2 = 0;
        int run0 = 0;

        reset_n = 1'b0;
        bus_a.enable = 1'b0;
        bus_b.enable = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_a_h",       32'(bus_a.h_count), 0);
        check("rst_a_running", 32'(bus_a.running), 0);
        check("rst_a_hsync",   32'(bus_a.hsync), 0);
        check("rst_b_hsync",   32'(bus_b.hsync), 1);
        check("rst_b_vsync",   32'(bus_b.vsync), 1);
        check("rst_b_de",      32'(bus_b.de), 0);
        check("rst_b_rd",      32'(bus_b.pix_rd_en), 0);

        reset_n = 1'b1;
        @(negedge clk);
        check("idle_a_h",       32'(bus_a.h_count), 0);
        check("idle_a_running", 32'(bus_a.running), 0);

        // Full-size line on dut_a; t equals h_count on line 0.
        bus_a.enable = 1'b1;
        for (int t = 0; t <= 1040; t++) begin
            @(negedge clk);
            if (t < 1040 && bus_a.hsync) hs_cnt++;
            case (t)
                0: begin
                    check("a0_h",  32'(bus_a.h_count), 0);
                    check("a0_rd", 32'(bus_a.pix_rd_en), 1);
                    check("a0_addr", 32'(bus_a.pix_addr), 0);
                    check("a0_fs", 32'(bus_a.frame_start), 1);
                    check("a0_de", 32'(bus_a.de), 0);
                end
                1:    check("a1_de", 32'(bus_a.de), 1);
                799: begin
                    check("a799_rd",   32'(bus_a.pix_rd_en), 1);
                    check("a799_addr", 32'(bus_a.pix_addr), 799);
                end
                800: begin
                    check("a800_rd", 32'(bus_a.pix_rd_en), 0);
                    check("a800_de", 32'(bus_a.de), 1);
                end
                801:  check("a801_de", 32'(bus_a.de), 0);
                856:  check("a856_hs", 32'(bus_a.hsync), 0);
                857:  check("a857_hs", 32'(bus_a.hsync), 1);
                976:  check("a976_hs", 32'(bus_a.hsync), 1);
                977:  check("a977_hs", 32'(bus_a.hsync), 0);
                1040: begin
                    check("a1040_h",    32'(bus_a.h_count), 0);
                    check("a1040_v",    32'(bus_a.v_count), 1);
                    check("a1040_addr", 32'(bus_a.pix_addr), 800);
                    check("a1040_fs",   32'(bus_a.frame_start), 0);
                end
                default: ;
            endcase
        end
        check("a_hsync_width", 32'(hs_cnt), 120);
        bus_a.enable = 1'b0;

        // Miniature raster: frame = 120 clks, s=0 is the first (0,0).
        bus_b.enable = 1'b1;
        for (int s = 0; s <= 515; s++) begin
            @(negedge clk);
            if (s < 120 && bus_b.pix_rd_en) rd1++;
            if (s >= 120 && s <= 245 && bus_b.pix_rd_en) rd2++;
            if (s >= 246 && s <= 366 && !bus_b.running) run0++;
            case (s)
                0: begin
                    check("b0_running", 32'(bus_b.running), 1);
                    check("b0_rd",      32'(bus_b.pix_rd_en), 1);
                    check("b0_fs",      32'(bus_b.frame_start), 1);
                end
                2:   check("b2_de",   32'(bus_b.de), 0);
                3:   check("b3_de",   32'(bus_b.de), 1);
                12:  check("b12_hs",  32'(bus_b.hsync), 1);
                13:  check("b13_hs",  32'(bus_b.hsync), 0);
                15:  check("b15_hs",  32'(bus_b.hsync), 0);
                16:  check("b16_hs",  32'(bus_b.hsync), 1);
                52: begin
                    check("b52_rd",   32'(bus_b.pix_rd_en), 1);
                    check("b52_addr", 32'(bus_b.pix_addr), 31);
                end
                53:  check("b53_rd",  32'(bus_b.pix_rd_en), 0);
                77:  check("b77_vs",  32'(bus_b.vsync), 1);
                78:  check("b78_vs",  32'(bus_b.vsync), 0);
                107: check("b107_vs", 32'(bus_b.vsync), 0);
                108: check("b108_vs", 32'(bus_b.vsync), 1);
                119: begin
                    check("b119_h",  32'(bus_b.h_count), 14);
                    check("b119_v",  32'(bus_b.v_count), 7);
                    check("b119_fs", 32'(bus_b.frame_start), 0);
                end
                120: check("b120_fs", 32'(bus_b.frame_start), 1);
                150: check("b150_v",  32'(bus_b.v_count), 2);
                200: check("b200_running", 32'(bus_b.running), 1);
                239: begin
                    check("b239_h",       32'(bus_b.h_count), 14);
                    check("b239_running", 32'(bus_b.running), 1);
                end
                240: begin
                    check("b240_running", 32'(bus_b.running), 0);
                    check("b240_h",       32'(bus_b.h_count), 0);
                    check("b240_fs",      32'(bus_b.frame_start), 0);
                end
                245: begin
                    check("b245_de", 32'(bus_b.de), 0);
                    check("b245_hs", 32'(bus_b.hsync), 1);
                    check("b245_vs", 32'(bus_b.vsync), 1);
                end
                246: check("b246_fs", 32'(bus_b.frame_start), 1);
                366: begin
                    check("b366_fs", 32'(bus_b.frame_start), 1);
                    check("b366_v",  32'(bus_b.v_count), 0);
                end
                485: begin
                    check("b485_h",       32'(bus_b.h_count), 14);
                    check("b485_running", 32'(bus_b.running), 1);
                end
                486: begin
                    check("b486_running", 32'(bus_b.running), 0);
                    check("b486_rd",      32'(bus_b.pix_rd_en), 0);
                end
                487: begin
                    check("b487_running", 32'(bus_b.running), 1);
                    check("b487_fs",      32'(bus_b.frame_start), 1);
                    check("b487_rd",      32'(bus_b.pix_rd_en), 1);
                end
                515: begin
                    check("b515_h",    32'(bus_b.h_count), 13);
                    check("b515_v",    32'(bus_b.v_count), 1);
                    check("b515_addr", 32'(bus_b.pix_addr), 16);
                    check("b515_hs",   32'(bus_b.hsync), 0);
                end
                default: ;
            endcase
            if (s == 150 || s == 261 || s == 396) bus_b.enable = 1'b0;
            if (s == 245 || s == 291 || s == 485) bus_b.enable = 1'b1;
        end
        check("b_frame1_reads",   32'(rd1), 32);
        check("b_frame2_reads",   32'(rd2), 32);
        check("b_rerun_no_gap",   32'(run0), 0);

        // Asynchronous reset between clock edges.
        reset_n = 1'b0;
        #1;
        check("arst_b_h",       32'(bus_b.h_count), 0);
        check("arst_b_v",       32'(bus_b.v_count), 0);
        check("arst_b_addr",    32'(bus_b.pix_addr), 0);
        check("arst_b_hs",      32'(bus_b.hsync), 1);
        check("arst_b_running", 32'(bus_b.running), 0);
        check("arst_a_running", 32'(bus_a.running), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rs_b_h",    32'(bus_b.h_count), 0);
        check("rs_b_rd",   32'(bus_b.pix_rd_en), 1);
        check("rs_b_fs",   32'(bus_b.frame_start), 1);
        @(negedge clk);
        check("rs_b_h1",    32'(bus_b.h_count), 1);
        check("rs_b_addr1", 32'(bus_b.pix_addr), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
